// File: rtl/mem_arbiter_2.sv
// Two-port round-robin arbiter in front of a single-ported memory with a variable-latency ack.
// Each access is granted from IDLE, holds the memory bus in BUSYx, then pulses done in RESPx.
module mem_arbiter_2 #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [AWIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0]  m0_wdata,
  output logic [WIDTH-1:0]  m0_rdata,
  output logic              m0_done,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [AWIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0]  m1_wdata,
  output logic [WIDTH-1:0]  m1_rdata,
  output logic              m1_done,

  output logic              mem_en,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StBusy0 = 3'd1,
    StBusy1 = 3'd2,
    StResp0 = 3'd3,
    StResp1 = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                mem_we_q, mem_we_d;
  logic [AWIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [WIDTH-1:0]    m0_rdata_q, m0_rdata_d;
  logic [WIDTH-1:0]    m1_rdata_q, m1_rdata_d;
  logic                grant1;

  // Under contention the port that did not win last time goes next.
  always_comb begin
    if (m0_req && m1_req) begin
      grant1 = ~last_grant_q;
    end else begin
      grant1 = m1_req;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          last_grant_d = grant1;
          if (grant1) begin
            state_d     = StBusy1;
            mem_we_d    = m1_we;
            mem_addr_d  = m1_addr;
            mem_wdata_d = m1_wdata;
          end else begin
            state_d     = StBusy0;
            mem_we_d    = m0_we;
            mem_addr_d  = m0_addr;
            mem_wdata_d = m0_wdata;
          end
        end
      end
      StBusy0: begin
        if (mem_ack) begin
          state_d = StResp0;
          if (!mem_we_q) begin
            m0_rdata_d = mem_rdata;
          end
        end
      end
      StBusy1: begin
        if (mem_ack) begin
          state_d = StResp1;
          if (!mem_we_q) begin
            m1_rdata_d = mem_rdata;
          end
        end
      end
      StResp0, StResp1: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign mem_en    = (state_q == StBusy0) || (state_q == StBusy1);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign m0_done   = (state_q == StResp0);
  assign m1_done   = (state_q == StResp1);
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter_2.sv
// Directed bench for mem_arbiter_2: reset, single read, contention, wait states,
// reset mid-access, stray acks and late input changes.
module tb_mem_arbiter_2;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned AWIDTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [AWIDTH-1:0] m0_addr, m1_addr;
  logic [WIDTH-1:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic              m0_done, m1_done;
  logic              mem_en, mem_we, mem_ack;
  logic [AWIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_2 #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_rdata  (m0_rdata),
    .m0_done   (m0_done),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_rdata  (m1_rdata),
    .m1_done   (m1_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_en"}, 64'(mem_en), 64'd0);
    check({tag, "_d0"}, 64'(m0_done), 64'd0);
    check({tag, "_d1"}, 64'(m1_done), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    tick();

    // Reset state
    check_idle_outs("rst");
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_rd0", 64'(m0_rdata), 64'd0);
    check("rst_rd1", 64'(m1_rdata), 64'd0);
    rst = 1'b0;
    tick();
    check_idle_outs("post_rst");

    // Single read with immediate ack
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    tick();
    check("rd_en", 64'(mem_en), 64'd1);
    check("rd_addr", 64'(mem_addr), 64'h100);
    check("rd_we", 64'(mem_we), 64'd0);
    check("rd_d0_early", 64'(m0_done), 64'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    check("rd_done", 64'(m0_done), 64'd1);
    check("rd_data", 64'(m0_rdata), 64'hDEADBEEF);
    check("rd_en_off", 64'(mem_en), 64'd0);
    check("rd_d1", 64'(m1_done), 64'd0);
    check("rd_rd1", 64'(m1_rdata), 64'd0);
    m0_req = 1'b0; mem_ack = 1'b0;
    tick();
    check_idle_outs("rd_idle");

    // Contention after reset: port 0 first, then port 1, then port 0 again
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    tick();
    check("c1_addr", 64'(mem_addr), 64'h10);
    mem_ack = 1'b1; mem_rdata = 32'hA;
    tick();
    check("c1_d0", 64'(m0_done), 64'd1);
    check("c1_d1", 64'(m1_done), 64'd0);
    check("c1_rd0", 64'(m0_rdata), 64'hA);
    check("c1_rd1", 64'(m1_rdata), 64'd0);
    m0_req = 1'b0; mem_ack = 1'b0;
    tick();
    check_idle_outs("c1_idle");
    tick();
    check("c2_en", 64'(mem_en), 64'd1);
    check("c2_addr", 64'(mem_addr), 64'h20);
    mem_ack = 1'b1; mem_rdata = 32'hB;
    m0_req = 1'b1;  // raised during port 1's response; must be ignored there
    tick();
    check("c2_d1", 64'(m1_done), 64'd1);
    check("c2_d0", 64'(m0_done), 64'd0);
    check("c2_rd1", 64'(m1_rdata), 64'hB);
    check("c2_rd0", 64'(m0_rdata), 64'hA);
    mem_ack = 1'b0;
    tick();
    check_idle_outs("c2_idle");
    m1_req = 1'b1;
    tick();
    check("c3_addr", 64'(mem_addr), 64'h10);
    mem_ack = 1'b1; mem_rdata = 32'hC;
    tick();
    check("c3_d0", 64'(m0_done), 64'd1);
    m0_req = 1'b0; m1_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Port 1 write with four wait-state cycles
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h40; m1_wdata = 32'h12345678;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("ws_en", 64'(mem_en), 64'd1);
      check("ws_we", 64'(mem_we), 64'd1);
      check("ws_addr", 64'(mem_addr), 64'h40);
      check("ws_wdata", 64'(mem_wdata), 64'h12345678);
      check("ws_d1", 64'(m1_done), 64'd0);
      m1_wdata = 32'hFFFF0000 + 32'(i);
      m1_addr = 32'h80;
      mem_rdata = 32'h55AA55AA;
      if (i == 3) mem_ack = 1'b1;
      tick();
    end
    check("ws_done", 64'(m1_done), 64'd1);
    check("ws_rd1", 64'(m1_rdata), 64'hB);
    check("ws_rd0", 64'(m0_rdata), 64'hC);
    check("ws_en_off", 64'(mem_en), 64'd0);
    m1_req = 1'b0; mem_ack = 1'b0;
    tick();
    check_idle_outs("ws_idle");

    // Reset during BUSY0 aborts without a done pulse
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h100; m0_wdata = 32'h77;
    tick();
    check("ra_en", 64'(mem_en), 64'd1);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h99;
    tick();
    check_idle_outs("ra");
    check("ra_addr", 64'(mem_addr), 64'd0);
    check("ra_we", 64'(mem_we), 64'd0);
    check("ra_wdata", 64'(mem_wdata), 64'd0);
    check("ra_rd0", 64'(m0_rdata), 64'd0);
    check("ra_rd1", 64'(m1_rdata), 64'd0);
    rst = 1'b0; m0_req = 1'b0;
    tick();
    check_idle_outs("ra_after");

    // Stray ack in IDLE
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick();
    check_idle_outs("sa_idle");
    check("sa_rd0", 64'(m0_rdata), 64'd0);

    // Address change during BUSY0, then stray ack during RESP0
    mem_ack = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    tick();
    m0_addr = 32'h200;
    tick();
    check("ic_en", 64'(mem_en), 64'd1);
    check("ic_addr", 64'(mem_addr), 64'h100);
    mem_ack = 1'b1; mem_rdata = 32'h0000CAFE;
    tick();
    check("ic_done", 64'(m0_done), 64'd1);
    check("ic_rd0", 64'(m0_rdata), 64'hCAFE);
    m0_req = 1'b0; mem_rdata = 32'h0BADF00D;
    tick();
    check_idle_outs("sa_resp");
    check("sa_resp_rd0", 64'(m0_rdata), 64'hCAFE);
    check("sa_resp_addr", 64'(mem_addr), 64'h100);
    mem_ack = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
